// File: rtl/register_pipe_pkg.sv
// register_pipe_pkg: shared clog2 helper for sizing the occupancy counter
package register_pipe_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/register_pipe_if.sv
// register_pipe_if: control, data and status bundle between a source and the pipeline
interface register_pipe_if #(
   parameter int n     = 8,
   parameter int DEPTH = 4
);
   import register_pipe_pkg::*;

   localparam int OCC_W = clog2(DEPTH + 1);

   logic             enable;
   logic             clear;
   logic             in_valid;
   logic [n-1:0]     in;
   logic             out_valid;
   logic [n-1:0]     out;
   logic [OCC_W-1:0] occupancy;

   modport master (output enable, clear, in_valid, in, input out_valid, out, occupancy);
   modport slave  (input enable, clear, in_valid, in, output out_valid, out, occupancy);

endinterface

// File: rtl/register_pipe_stage.sv
// pipe_stage: one data+valid register with load enable, valid flush and optional data gating
module pipe_stage #(
   parameter int           n         = 8,
   parameter logic [n-1:0] RESET_VAL = '0,
   parameter bit           GATE_DATA = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic         v_i,
   input  logic [n-1:0] d_i,
   output logic         v_o,
   output logic [n-1:0] d_o
);

   logic [n-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // clear only drops valid; data follows enable and, when gated, the incoming valid
   always_comb begin
      valid_d = clr_i ? 1'b0 : en_i ? v_i : valid_q;
      data_d  = (en_i && !clr_i && (v_i || !GATE_DATA)) ? d_i : data_q;
   end

   // stage registers, asynchronously returned to their reset word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign d_o = data_q;
   assign v_o = valid_q;

endmodule

// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage stallable, flushable delay line with valid tracking and occupancy
module register_pipe
   import register_pipe_pkg::*;
#(
   parameter int           n         = 8,
   parameter int           DEPTH     = 4,
   parameter logic [n-1:0] RESET_VAL = '0,
   parameter bit           GATE_DATA = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   register_pipe_if.slave bus
);

   localparam int OCC_W = clog2(DEPTH + 1);

   logic [DEPTH:0][n-1:0] data_w;
   logic [DEPTH:0]        valid_w;
   logic [OCC_W-1:0]      occ_q, occ_d;

   assign data_w[0]  = bus.in;
   assign valid_w[0] = bus.in_valid;

   for (genvar g = 0; g < DEPTH; g++) begin : stg
      pipe_stage #(.n(n), .RESET_VAL(RESET_VAL), .GATE_DATA(GATE_DATA)) u_stage (
         .clk   (clk),
         .reset (reset),
         .en_i  (bus.enable),
         .clr_i (bus.clear),
         .v_i   (valid_w[g]),
         .d_i   (data_w[g]),
         .v_o   (valid_w[g+1]),
         .d_o   (data_w[g+1])
      );
   end

   // count words entering minus the word leaving the last stage on each advance
   always_comb
      occ_d = bus.clear  ? '0 :
              bus.enable ? occ_q + OCC_W'(valid_w[0]) - OCC_W'(valid_w[DEPTH]) :
                           occ_q;

   // occupancy register, emptied with the stages on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) occ_q <= '0;
      else        occ_q <= occ_d;
   end

   assign bus.out       = data_w[DEPTH];
   assign bus.out_valid = valid_w[DEPTH];
   assign bus.occupancy = occ_q;

   a_occ_popcount: assert property (@(posedge clk) disable iff (!reset)
      int'(occ_q) == $countones(valid_w[DEPTH:1]));
   a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
      int'(occ_q) <= DEPTH);

endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: vector table, corner sequences and scoreboard for register_pipe
module tb_register_pipe;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   register_pipe_if #(.n(8), .DEPTH(4)) ia ();
   register_pipe_if #(.n(8), .DEPTH(4)) ib ();
   register_pipe_if #(.n(8), .DEPTH(1)) ic ();

   register_pipe #(.n(8), .DEPTH(4), .RESET_VAL(8'hC3), .GATE_DATA(1'b0)) u_a (.clk(clk), .reset(reset), .bus(ia));
   register_pipe #(.n(8), .DEPTH(4), .RESET_VAL(8'hC3), .GATE_DATA(1'b1)) u_b (.clk(clk), .reset(reset), .bus(ib));
   register_pipe #(.n(8), .DEPTH(1), .RESET_VAL(8'h0F), .GATE_DATA(1'b0)) u_c (.clk(clk), .reset(reset), .bus(ic));

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      bit         en, cl, iv;
      logic [7:0] d;
      bit         ov;
      logic [2:0] occ;
      bit         co;
      logic [7:0] out;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit en, input bit cl, input bit iv, input logic [7:0] d);
      ia.enable = en; ia.clear = cl; ia.in_valid = iv; ia.in = d;
      ib.enable = en; ib.clear = cl; ib.in_valid = iv; ib.in = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ab(input string nm, input bit ov, input logic [2:0] occ);
      chk({nm, "_ov_a"}, ia.out_valid, ov);
      chk({nm, "_ov_b"}, ib.out_valid, ov);
      chk({nm, "_occ_a"}, ia.occupancy, occ);
      chk({nm, "_occ_b"}, ib.occupancy, occ);
   endtask

   task automatic chk_out(input string nm, input logic [7:0] out);
      chk({nm, "_out_a"}, ia.out, out);
      chk({nm, "_out_b"}, ib.out, out);
   endtask

   // scoreboard on u_a: words pushed on enabled edges, popped when they reach the last stage
   always @(posedge clk) begin : sb_mon
      bit s_en, s_cl, s_iv, s_rst;
      logic [7:0] s_d;
      s_en = ia.enable; s_cl = ia.clear; s_iv = ia.in_valid; s_d = ia.in; s_rst = reset;
      #1;
      if (s_rst) begin
         if (s_cl) sb_q.delete();
         else if (s_en) begin
            if (s_iv) sb_q.push_back(s_d);
            if (ia.out_valid) begin
               if (sb_q.size() == 0) chk("sb_nonempty", sb_q.size(), 1);
               else chk("sb_word", ia.out, sb_q.pop_front());
            end
         end
         chk("sb_occ", ia.occupancy, sb_q.size() + int'(ia.out_valid));
      end
   end

   initial begin
      vec_t lat[7];
      bit en, cl, iv, exp_ov;
      logic [7:0] d, last_w;
      logic [7:0] q2[$];
      lat[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'hC3};
      lat[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'hC3};
      lat[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'hC3};
      lat[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h11};
      lat[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h22};
      lat[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h33};
      lat[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00};
      drive(0, 0, 0, 8'h00);
      ic.enable = 0; ic.clear = 0; ic.in_valid = 0; ic.in = 8'h00;
      // asynchronous reset before any clock edge
      #2 reset = 1'b0;
      #1;
      chk_ab("rst0", 0, 3'd0);
      chk_out("rst0", 8'hC3);
      chk("rst0_ov_c", ic.out_valid, 0);
      chk("rst0_occ_c", ic.occupancy, 0);
      chk("rst0_out_c", ic.out, 8'h0F);
      @(negedge clk) reset = 1'b1;
      // latency table
      for (int i = 0; i < 7; i++) begin
         drive(lat[i].en, lat[i].cl, lat[i].iv, lat[i].d);
         tick();
         chk_ab($sformatf("lat%0d", i), lat[i].ov, lat[i].occ);
         if (lat[i].co) chk_out($sformatf("lat%0d", i), lat[i].out);
      end
      // stall with two words in flight
      drive(1, 0, 1, 8'h44); tick();
      drive(1, 0, 1, 8'h55); tick();
      drive(1, 0, 0, 8'h00); tick(); tick();
      chk_ab("stall_pre", 1, 3'd2);
      chk_out("stall_pre", 8'h44);
      drive(0, 0, 1, 8'hEE);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_ab($sformatf("stall%0d", i), 1, 3'd2);
         chk_out($sformatf("stall%0d", i), 8'h44);
      end
      drive(1, 0, 0, 8'h00); tick();
      chk_ab("resume0", 1, 3'd1);
      chk_out("resume0", 8'h55);
      tick();
      chk_ab("resume1", 0, 3'd0);
      // flush with a simultaneous valid input
      drive(1, 0, 1, 8'h66); tick();
      drive(1, 0, 1, 8'h77); tick();
      chk_ab("flush_pre", 0, 3'd2);
      drive(1, 1, 1, 8'h88); tick();
      chk_ab("flush", 0, 3'd0);
      drive(1, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_ab($sformatf("flush_post%0d", i), 0, 3'd0);
      end
      // reset mid-stream with three words inside
      drive(1, 0, 1, 8'h99); tick();
      drive(1, 0, 1, 8'hAB); tick();
      drive(1, 0, 1, 8'hCD); tick();
      drive(1, 0, 0, 8'h00); tick();
      chk_ab("mid_pre", 1, 3'd3);
      chk_out("mid_pre", 8'h99);
      #2 reset = 1'b0;
      sb_q.delete();
      #1;
      chk_ab("mid_rst", 0, 3'd0);
      chk_out("mid_rst", 8'hC3);
      @(negedge clk) reset = 1'b1;
      // alternating bubbles: gated data holds 0xAA in invalid slots
      for (int k = 1; k <= 12; k++) begin
         drive(1, 0, k[0], k[0] ? 8'hAA : 8'h55);
         tick();
         if (k == 3) chk_ab("bub3", 0, 3'd2);
         if (k >= 4) begin
            chk_ab($sformatf("bub%0d", k), !k[0], 3'd2);
            chk($sformatf("bub%0d_out_a", k), ia.out, k[0] ? 8'h55 : 8'hAA);
            chk($sformatf("bub%0d_out_b", k), ib.out, 8'hAA);
         end
      end
      drive(1, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) tick();
      chk_ab("drain", 0, 3'd0);
      chk("sb_drained", sb_q.size(), 0);
      drive(0, 0, 0, 8'h00);
      // DEPTH=1 random run against a queue model
      exp_ov = 0;
      last_w = 8'h00;
      for (int i = 0; i < 10000; i++) begin
         en = $urandom_range(0, 3) != 0;
         cl = $urandom_range(0, 7) == 0;
         iv = $urandom_range(0, 1) == 1;
         d  = 8'($urandom);
         ic.enable = en; ic.clear = cl; ic.in_valid = iv; ic.in = d;
         tick();
         if (cl) begin
            q2.delete();
            exp_ov = 0;
         end else if (en) begin
            exp_ov = iv;
            if (iv) q2.push_back(d);
         end
         chk("c_ov", ic.out_valid, exp_ov);
         chk("c_occ", ic.occupancy, exp_ov);
         if (exp_ov) begin
            if (!cl && en) last_w = q2.pop_front();
            chk("c_out", ic.out, last_w);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
